mem_responder: RTL and testbench
================================

# mem_responder

Bus-target memory block that answers the CPU's byte-addressed load, store and fetch requests over a valid/ready handshake. It holds the 16-bit word store internally and performs byte stores as an internal read-modify-write, so the CPU datapath no longer merges lanes itself. Full 16-bit words are returned for instruction fetch, and the addressed byte is returned for loads. It sits between the CPU core and program/data storage.

## Interface
- ADDR_W, 8, byte-address width; storage depth is 2^(ADDR_W-1) 16-bit words (128 at default).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = byte store, 0 = read.
- req_addr  in  ADDR_W  byte address; bit 0 selects the lane (0 = [7:0], 1 = [15:8]).
- req_wdata  in  8  store byte.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  16  full word: the read word on reads, the merged word on stores.
- rsp_byte  out  8  lane of rsp_rdata selected by the latched req_addr[0].
- out_port  out  8  MMIO output register; constant 0 when the macro is absent.

## Operation
- States: IDLE, FETCH, COMMIT, RESP.
- req_ready = 1 only in IDLE. rsp_valid = 1 only in RESP.
- **IDLE:** on req_valid, latch addr, we and wdata, then go to FETCH. If req_valid is low, stay in IDLE.
- **FETCH:** capture memory[addr[ADDR_W-1:1]] into the word register.
  - Read: rsp_rdata takes the word, then go to RESP.
  - Store: go to COMMIT.
- **COMMIT:** the merged word is the old word with the selected lane replaced by wdata. Write the merged word to memory and to rsp_rdata, then go to RESP.
- **RESP:** one cycle, then go to IDLE unconditionally.
- Request inputs are ignored outside IDLE. The requester holds nothing after acceptance.
- The memory array is written only at the rising edge that leaves COMMIT.
- Memory contents are not reset. The bench preloads the array named `memory`, indexed by word.

## Timing
- **Reset values:** state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 16'h0000, rsp_byte = 8'h00, out_port = 8'h00.
- **Read latency:** accept cycle, FETCH, RESP. rsp_valid is high in the 2nd cycle after the accept cycle.
- **Store latency:** accept, FETCH, COMMIT, RESP. rsp_valid is high in the 3rd cycle after the accept cycle.
- **Back-to-back requests:** the next request is accepted in the cycle after RESP. Read throughput is 1 per 3 cycles; store throughput is 1 per 4 cycles.
- rsp_rdata and rsp_byte hold their value after RESP until the next response.
- **Reset mid-operation:** returns immediately to IDLE.
  - A store aborted in FETCH or COMMIT leaves memory unchanged.
  - An in-flight response is dropped.
- **Address wrap:** the highest byte address maps to the upper lane of the last word. There is no out-of-range case.

## Configuration
- MEMRESP_MMIO_EN defined:
  - Byte address 2^ADDR_W-1 (8'hFF) is the out_port register.
  - A store there updates out_port at the COMMIT edge and leaves memory untouched.
  - A read there returns rsp_rdata = {out_port, 8'h00} and rsp_byte = out_port.
  - Timing is identical to ordinary accesses.
- MEMRESP_MMIO_EN absent: 8'hFF is ordinary memory (word 127, upper lane), and out_port is tied to 0.

## Test plan
- **Reset:** assert rst_n = 0 mid-run → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, out_port = 0.
- **Fetch:** preload memory[3] = 16'hA50C, read addr 8'h06 → rsp_valid 2 cycles after accept, rsp_rdata = 16'hA50C, rsp_byte = 8'h0C. Read addr 8'h07 → rsp_byte = 8'hA5.
- **Byte store merge:** memory[5] = 16'h1234, store 8'hAB to addr 8'h0B → rsp_valid 3 cycles after accept, rsp_rdata = 16'hAB34, memory[5] = 16'hAB34. A follow-up read of 8'h0A gives rsp_byte = 8'h34.
- **Handshake:** hold req_valid = 1 continuously with 3 reads → req_ready low in FETCH and RESP, accepts exactly every 3rd cycle, 3 rsp_valid pulses.
- **Abort:** memory[2] = 16'h00FF, store 8'h11 to 8'h04, pulse rst_n low during COMMIT → memory[2] stays 16'h00FF and no rsp_valid pulse.
- **MMIO:** with MEMRESP_MMIO_EN, store 8'h5A to 8'hFF → out_port = 8'h5A and memory[127] unchanged. Without the macro, the same store gives memory[127][15:8] = 8'h5A and out_port = 0.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressed bus-target memory: 16-bit word store, byte stores via internal read-modify-write.
// Optional MEMRESP_MMIO_EN maps the top byte address onto the out_port register.
module mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [7:0]        rsp_byte,
  output logic [7:0]        out_port
);

  localparam int DEPTH = 2 ** (ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        out_port_q, out_port_d;

  logic [15:0]       memory [DEPTH];
  logic              is_mmio;
  logic              mem_we;
  logic [15:0]       rd_word;
  logic [15:0]       merged;

  always_comb begin
`ifdef MEMRESP_MMIO_EN
    is_mmio = (addr_q == {ADDR_W{1'b1}});
`else
    is_mmio = 1'b0;
`endif
    rd_word = is_mmio ? {out_port_q, 8'h00} : memory[addr_q[ADDR_W-1:1]];
    merged  = addr_q[0] ? {wdata_q, word_q[7:0]} : {word_q[15:8], wdata_q};
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    byte_d     = byte_q;
    out_port_d = out_port_q;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = FETCH;
        end
      end
      FETCH: begin
        word_d = rd_word;
        if (we_q) begin
          state_d = COMMIT;
        end else begin
          rdata_d = rd_word;
          byte_d  = addr_q[0] ? rd_word[15:8] : rd_word[7:0];
          state_d = RESP;
        end
      end
      COMMIT: begin
        rdata_d = merged;
        byte_d  = addr_q[0] ? merged[15:8] : merged[7:0];
        if (is_mmio) begin
          out_port_d = wdata_q;
        end else begin
          mem_we = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifndef MEMRESP_MMIO_EN
    out_port_d = 8'h00;
`endif
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      word_q     <= 16'h0000;
      rdata_q    <= 16'h0000;
      byte_q     <= 8'h00;
      out_port_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      byte_q     <= byte_d;
      out_port_q <= out_port_d;
    end
  end

  // NOTE: the storage array has no reset; a reset only returns the FSM to IDLE, which
  // also guarantees an aborted store never reaches the write enable below.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      memory[addr_q[ADDR_W-1:1]] <= merged;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_byte  = byte_q;
  assign out_port  = out_port_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against a word-array model.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_byte;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem [128];
  logic [7:0]  model_out;

  mem_responder #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_byte  (rsp_byte),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_mmio_addr(input logic [7:0] a);
`ifdef MEMRESP_MMIO_EN
    return (a == 8'hFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [7:0] a);
    if (is_mmio_addr(a)) return {model_out, 8'h00};
    return model_mem[a / 2];
  endfunction

  function automatic logic [15:0] model_store(input logic [7:0] a, input logic [7:0] d);
    logic [15:0] w;
    w = model_read(a);
    if (a % 2 == 1) w = (w & 16'h00FF) | (16'(d) << 8);
    else            w = (w & 16'hFF00) | 16'(d);
    if (is_mmio_addr(a)) model_out = d;
    else                 model_mem[a / 2] = w;
    return w;
  endfunction

  function automatic logic [7:0] lane(input logic [15:0] w, input logic [7:0] a);
    return (a % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic preload(input int idx, input logic [15:0] v);
    dut.memory[idx] = v;
    model_mem[idx]  = v;
  endtask

  // One complete transaction from IDLE back to IDLE, with latency/data/hold checks.
  task automatic xact(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] exp_w;
    int          n;
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    exp_w = we ? model_store(a, d) : model_read(a);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check(we ? "store_latency" : "read_latency", 32'(n), we ? 32'd3 : 32'd2);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_w));
    check("rsp_byte", 32'(rsp_byte), 32'(lane(exp_w, a)));
    step();
    check("valid_drop", 32'(rsp_valid), 32'd0);
    check("hold_rdata", 32'(rsp_rdata), 32'(exp_w));
    check("hold_byte", 32'(rsp_byte), 32'(lane(exp_w, a)));
    check("out_port", 32'(out_port), 32'(model_out));
  endtask

  initial begin
    logic [15:0] exp_q [$];
    logic [7:0]  hs_addr [3];
    int          accepts;
    int          pulses;
    int          hs_idx;
    int          bad_valid;
    logic [7:0]  ra;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    model_out = 8'h00;
    for (int i = 0; i < 128; i++) preload(i, 16'($urandom));
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_byte", 32'(rsp_byte), 32'd0);
    check("rst_out_port", 32'(out_port), 32'd0);
    rst_n = 1'b1;
    step();

    // Fetch both lanes of one word.
    preload(3, 16'hA50C);
    xact(1'b0, 8'h06, 8'h00);
    xact(1'b0, 8'h07, 8'h00);

    // Byte store merge, then read the untouched lane.
    preload(5, 16'h1234);
    xact(1'b1, 8'h0B, 8'hAB);
    check("mem5_merged", 32'(dut.memory[5]), 32'h0000AB34);
    xact(1'b0, 8'h0A, 8'h00);

    // Back-to-back reads with req_valid held high.
    hs_addr[0] = 8'h10;
    hs_addr[1] = 8'h23;
    hs_addr[2] = 8'h7E;
    accepts = 0;
    pulses  = 0;
    hs_idx  = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = hs_addr[0];
    for (int cyc = 0; cyc < 9; cyc++) begin
      check("hs_ready", 32'(req_ready), (cyc % 3 == 0) ? 32'd1 : 32'd0);
      check("hs_valid", 32'(rsp_valid), (cyc % 3 == 2) ? 32'd1 : 32'd0);
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (exp_q.size() > 0) check("hs_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      end
      if (req_ready === 1'b1) begin
        accepts++;
        exp_q.push_back(model_read(req_addr));
      end
      step();
      if (req_ready !== 1'b1 && hs_idx < 2 && cyc % 3 == 0) begin
        hs_idx++;
        req_addr = hs_addr[hs_idx];
      end
    end
    req_valid = 1'b0;
    check("hs_accepts", 32'(accepts), 32'd3);
    check("hs_pulses", 32'(pulses), 32'd3);

    // Store aborted by reset during COMMIT.
    preload(2, 16'h00FF);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h04;
    req_wdata = 8'h11;
    step();
    req_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    model_out = 8'h00;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_out_port", 32'(out_port), 32'd0);
    rst_n = 1'b1;
    bad_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b0) bad_valid++;
    end
    check("abort_no_rsp", 32'(bad_valid), 32'd0);
    check("abort_mem2", 32'(dut.memory[2]), 32'h000000FF);

    // Top byte address: MMIO register or ordinary upper lane of the last word.
    preload(127, 16'h3C96);
    xact(1'b1, 8'hFF, 8'h5A);
`ifdef MEMRESP_MMIO_EN
    check("mmio_out_port", 32'(out_port), 32'h5A);
    check("mmio_mem127", 32'(dut.memory[127]), 32'h00003C96);
`else
    check("wrap_out_port", 32'(out_port), 32'h00);
    check("wrap_mem127", 32'(dut.memory[127]), 32'h00005A96);
`endif
    xact(1'b0, 8'hFF, 8'h00);
    xact(1'b0, 8'hFE, 8'h00);

    // Random mixed traffic against the model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      if (i % 8 == 0) ra = 8'hFF;
      xact(1'($urandom_range(0, 1)), ra, 8'($urandom));
    end
    for (int i = 0; i < 128; i++) begin
      if (dut.memory[i] !== model_mem[i]) check("final_mem", 32'(dut.memory[i]), 32'(model_mem[i]));
    end
    check("final_mem_last", 32'(dut.memory[127]), 32'(model_mem[127]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
